// File: rtl/outer_prod_rc.sv
// Rate-coded outer-product accumulator: every enabled cycle it ANDs unary row/column bits
// and adds or subtracts each product bit into a signed per-element accumulator.
module outer_prod_rc #(
    parameter int ROWNUM      = 2,
    parameter int COLNUM      = 2,
    parameter int BITWIDTH    = 4,
    parameter int OUTBITWIDTH = 16
) (
    input  logic                                  iClk,
    input  logic                                  iRst,
    input  logic                                  iEn,
    input  logic                                  iClr,
    input  logic [ROWNUM*BITWIDTH-1:0]            iData0,
    input  logic [COLNUM*BITWIDTH-1:0]            iData1,
    output logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0]  oData
);

    localparam int M     = BITWIDTH - 1;
    localparam int NELEM = ROWNUM * COLNUM;

    function automatic logic [M-1:0] elemMag(input logic [BITWIDTH-1:0] e);
        return e[M-1:0];
    endfunction

    function automatic logic elemSign(input logic [BITWIDTH-1:0] e);
        return e[M];
    endfunction

    logic [2*M-1:0]         cntR;
    logic [M-1:0]           loS;
    logic [M-1:0]           hiS;
    logic [ROWNUM-1:0]      rowBitS;
    logic [ROWNUM-1:0]      rowSignS;
    logic [COLNUM-1:0]      colBitS;
    logic [COLNUM-1:0]      colSignS;
    logic [OUTBITWIDTH-1:0] stepS [NELEM];

    assign loS = cntR[M-1:0];
    assign hiS = cntR[2*M-1:M];

    // Unary encoding: the fast counter half drives rows, the slow half drives columns.
    // A zero magnitude (including negative zero) never produces a one bit.
    always_comb begin
        rowBitS  = {ROWNUM{1'b0}};
        rowSignS = {ROWNUM{1'b0}};
        colBitS  = {COLNUM{1'b0}};
        colSignS = {COLNUM{1'b0}};
        for (int i = 0; i < ROWNUM; i++) begin
            rowBitS[i]  = loS < elemMag(iData0[i*BITWIDTH +: BITWIDTH]);
            rowSignS[i] = elemSign(iData0[i*BITWIDTH +: BITWIDTH]);
        end
        for (int j = 0; j < COLNUM; j++) begin
            colBitS[j]  = hiS < elemMag(iData1[j*BITWIDTH +: BITWIDTH]);
            colSignS[j] = elemSign(iData1[j*BITWIDTH +: BITWIDTH]);
        end
    end

    // Per-element step: +1, -1 (all ones) or 0 depending on product bit and sign.
    always_comb begin
        for (int k = 0; k < NELEM; k++) begin
            stepS[k] = {OUTBITWIDTH{1'b0}};
        end
        for (int i = 0; i < ROWNUM; i++) begin
            for (int j = 0; j < COLNUM; j++) begin
                if (rowBitS[i] & colBitS[j]) begin
                    if (rowSignS[i] ^ colSignS[j]) begin
                        stepS[i*COLNUM+j] = {OUTBITWIDTH{1'b1}};
                    end else begin
                        stepS[i*COLNUM+j] = {{(OUTBITWIDTH-1){1'b0}}, 1'b1};
                    end
                end else begin
                    stepS[i*COLNUM+j] = {OUTBITWIDTH{1'b0}};
                end
            end
        end
    end

    // Counter and accumulators; the accumulators are the output register itself.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            cntR  <= {(2*M){1'b0}};
            oData <= {(NELEM*OUTBITWIDTH){1'b0}};
        end else if (iClr) begin
            cntR  <= {(2*M){1'b0}};
            oData <= {(NELEM*OUTBITWIDTH){1'b0}};
        end else if (iEn) begin
            cntR <= cntR + {{(2*M-1){1'b0}}, 1'b1};
            for (int k = 0; k < NELEM; k++) begin
                oData[k*OUTBITWIDTH +: OUTBITWIDTH] <= oData[k*OUTBITWIDTH +: OUTBITWIDTH] + stepS[k];
            end
        end else begin
            cntR  <= cntR;
            oData <= oData;
        end
    end

endmodule

// File: tb/tb_outer_prod_rc.sv
// Directed bench for outer_prod_rc: hand-computed outer products over partial,
// full and repeated counter periods, clear, reset and zero operands.
module tb_outer_prod_rc;

    logic        iClk = 1'b0;
    logic        iRst = 1'b1;
    logic        iEn  = 1'b0;
    logic        iClr = 1'b0;
    logic [7:0]  iData0 = 8'h00;
    logic [7:0]  iData1 = 8'h00;
    logic [63:0] oData;

    int total = 0;
    int bad   = 0;

    outer_prod_rc #(.ROWNUM(2), .COLNUM(2), .BITWIDTH(4), .OUTBITWIDTH(16)) dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iEn   (iEn),
        .iClr  (iClr),
        .iData0(iData0),
        .iData1(iData1),
        .oData (oData)
    );

    always #5 iClk = ~iClk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkAcc(input string tag, input logic [15:0] e00, input logic [15:0] e01,
                            input logic [15:0] e10, input logic [15:0] e11);
        checkVal({tag, "_acc00"}, {48'h0, oData[15:0]},  {48'h0, e00});
        checkVal({tag, "_acc01"}, {48'h0, oData[31:16]}, {48'h0, e01});
        checkVal({tag, "_acc10"}, {48'h0, oData[47:32]}, {48'h0, e10});
        checkVal({tag, "_acc11"}, {48'h0, oData[63:48]}, {48'h0, e11});
    endtask

    // Advance n rising edges; inputs change and outputs are read 1 ns after the edge.
    task automatic edges(input int n);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    initial begin
        // Reset then hold
        edges(2);
        checkVal("reset", oData, 64'h0);
        iRst = 1'b0;
        iData0 = {4'b1110, 4'b0010};   // a1=-6, a0=+2
        iData1 = {4'b0100, 4'b1100};   // b1=+4, b0=-4
        for (int n = 0; n < 10; n++) begin
            edges(1);
            checkVal("hold_idle", oData, 64'h0);
        end

        // Partial period (H=0), full period, second period
        iEn = 1'b1;
        edges(8);
        checkAcc("p8", 16'hFFFE, 16'h0002, 16'h0006, 16'hFFFA);
        edges(56);
        checkAcc("p64", 16'hFFF8, 16'h0008, 16'h0018, 16'hFFE8);
        edges(64);
        checkAcc("p128", 16'hFFF0, 16'h0010, 16'h0030, 16'hFFD0);

        // Enable low holds state
        iEn = 1'b0;
        edges(5);
        checkAcc("hold_en0", 16'hFFF0, 16'h0010, 16'h0030, 16'hFFD0);

        // Clear mid-period with enable high, then a fresh period
        iEn = 1'b1;
        edges(30);
        iClr = 1'b1;
        edges(1);
        iClr = 1'b0;
        checkVal("clr", oData, 64'h0);
        edges(8);
        checkAcc("clr_p8", 16'hFFFE, 16'h0002, 16'h0006, 16'hFFFA);
        edges(56);
        checkAcc("clr_p64", 16'hFFF8, 16'h0008, 16'h0018, 16'hFFE8);

        // Reset mid-period discards partial sums and restarts the counter
        edges(21);
        iRst = 1'b1;
        edges(1);
        iRst = 1'b0;
        checkVal("rst_mid", oData, 64'h0);
        edges(8);
        checkAcc("rst_p8", 16'hFFFE, 16'h0002, 16'h0006, 16'hFFFA);

        // Zero and negative-zero operands
        iClr = 1'b1;
        edges(1);
        iClr = 1'b0;
        iData0 = {4'b1110, 4'b0000};   // a1=-6, a0=0
        iData1 = {4'b1000, 4'b1100};   // b1=-0, b0=-4
        edges(64);
        checkAcc("zero_p64", 16'h0000, 16'h0000, 16'h0018, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
